// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS run controller: FSM states,
// HALT opcode and register-index width.
package mips_ctrl_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam logic [5:0]  HALT_OPCODE = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } run_state_e;

  function automatic logic is_halt_instr(input logic [31:0] instr);
    return (instr[31:26] == HALT_OPCODE);
  endfunction

  function automatic logic is_busy_state(input run_state_e st);
    return (st == ST_LOAD) || (st == ST_RUN) || (st == ST_DUMP);
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// RUN-phase cycle watchdog: counts enabled cycles from 1 and flags the cycle
// whose count equals a non-zero limit.
module run_watchdog #(
  parameter int TO_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic            i_clear,
  input  logic [TO_W-1:0] i_limit,
  output logic            o_expired
);

  localparam logic [TO_W-1:0] ONE_TO = TO_W'(1);

  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_limit_m1;

  assign w_limit_m1 = i_limit - ONE_TO;

  // Completed-cycle counter; the current cycle's count is r_cnt + 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + ONE_TO;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Expiry decode; a zero limit disables the watchdog.
  always_comb begin
    o_expired = 1'b0;
    if (i_enable && (i_limit != '0) && (r_cnt == w_limit_m1)) begin
      o_expired = 1'b1;
    end else begin
      o_expired = 1'b0;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Load/run/dump sequencer for a MIPS core. Define RUN_CTRL_DUMP_EN to enable
// the register dump phase; otherwise RUN goes straight to DONE.
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int NDUMP  = 10,
  parameter int TO_W   = 16
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MEM_AW-1:0]    prog_len,
  input  logic [TO_W-1:0]      timeout_limit,
  input  logic                 ld_valid,
  input  logic [31:0]          ld_data,
  output logic                 ld_ready,
  output logic                 imem_we,
  output logic [MEM_AW-1:0]    imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 cpu_run,
  input  logic                 cpu_halted,
  output logic [REG_IDX_W-1:0] dbg_raddr,
  input  logic [31:0]          dbg_rdata,
  output logic                 dump_valid,
  output logic [REG_IDX_W-1:0] dump_idx,
  output logic [31:0]          dump_data,
  input  logic                 dump_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  localparam logic [MEM_AW-1:0] ONE_AW = MEM_AW'(1);

`ifdef RUN_CTRL_DUMP_EN
  localparam run_state_e RUN_EXIT = ST_DUMP;
  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NDUMP - 1);
  localparam logic [REG_IDX_W-1:0] ONE_IDX  = REG_IDX_W'(1);
`else
  localparam run_state_e RUN_EXIT = ST_DONE;
`endif

  run_state_e        r_state;
  run_state_e        w_next;
  logic [MEM_AW-1:0] r_len;
  logic [MEM_AW-1:0] r_wcnt;
  logic [TO_W-1:0]   r_limit;
  logic              r_first;
  logic              r_timeout;

  logic w_start_ok;
  logic w_load_acc;
  logic w_last_word;
  logic w_halt;
  logic w_expired;
  logic w_set_to;
  logic w_in_run;

  assign w_in_run    = (r_state == ST_RUN);
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_load_acc  = (r_state == ST_LOAD) && ld_valid;
  assign w_last_word = (r_wcnt == (r_len - ONE_AW));
  // The halt flag is stale on the first RUN cycle, so it is masked there.
  assign w_halt      = w_in_run && cpu_halted && !r_first;
  assign w_set_to    = w_in_run && !w_halt && w_expired;

  run_watchdog #(
    .TO_W(TO_W)
  ) u_watchdog (
    .i_clk     (clk1),
    .i_rst_n   (rst_n),
    .i_enable  (w_in_run),
    .i_clear   (!w_in_run),
    .i_limit   (r_limit),
    .o_expired (w_expired)
  );

`ifdef RUN_CTRL_DUMP_EN
  logic [REG_IDX_W-1:0] r_idx;
  logic                 w_dump_acc;
  logic                 w_last_dump;

  assign w_dump_acc  = (r_state == ST_DUMP) && dump_ready;
  assign w_last_dump = (r_idx == LAST_IDX);

  // Dump index: restarts on each accepted start, advances per accepted beat.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_start_ok) begin
      r_idx <= '0;
    end else if (w_dump_acc) begin
      r_idx <= r_idx + ONE_IDX;
    end else begin
      r_idx <= r_idx;
    end
  end

  // Dump stream: index and data are held by r_idx while dump_ready is low.
  always_comb begin
    dump_valid = 1'b0;
    dump_idx   = '0;
    dbg_raddr  = '0;
    dump_data  = 32'd0;
    if (r_state == ST_DUMP) begin
      dump_valid = 1'b1;
      dump_idx   = r_idx;
      dbg_raddr  = r_idx;
      dump_data  = dbg_rdata;
    end else begin
      dump_valid = 1'b0;
    end
  end
`else
  logic w_unused;
  assign w_unused   = ^{dump_ready, dbg_rdata};
  assign dump_valid = 1'b0;
  assign dump_idx   = '0;
  assign dbg_raddr  = '0;
  assign dump_data  = 32'd0;
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next = (prog_len == '0) ? ST_RUN : ST_LOAD;
        end else begin
          w_next = r_state;
        end
      end
      ST_LOAD: begin
        if (w_load_acc && w_last_word) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (w_halt || w_expired) begin
          w_next = RUN_EXIT;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DUMP: begin
`ifdef RUN_CTRL_DUMP_EN
        if (w_dump_acc && w_last_dump) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_DUMP;
        end
`else
        w_next = ST_DONE;
`endif
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State and sequence-context registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_wcnt    <= '0;
      r_limit   <= '0;
      r_first   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next == ST_RUN) && (r_state != ST_RUN);
      if (w_start_ok) begin
        r_len     <= prog_len;
        r_limit   <= timeout_limit;
        r_wcnt    <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_load_acc) begin
          r_wcnt <= r_wcnt + ONE_AW;
        end
        if (w_set_to) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  // Status and program-load outputs decoded from the state register.
  always_comb begin
    cpu_run    = (r_state == ST_RUN);
    busy       = is_busy_state(r_state);
    done       = (r_state == ST_DONE);
    timeout    = r_timeout;
    ld_ready   = (r_state == ST_LOAD);
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = 32'd0;
    if (r_state == ST_LOAD) begin
      imem_we    = ld_valid;
      imem_addr  = r_wcnt;
      imem_wdata = ld_data;
    end else begin
      imem_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: scenario table plus hand-written reset
// and edge sequences; adapts to builds with or without RUN_CTRL_DUMP_EN.
module tb_mips_run_ctrl;

  localparam int MEM_AW = 10;
  localparam int NDUMP  = 10;
  localparam int TO_W   = 16;
  localparam int BUDGET = 4000;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [MEM_AW-1:0] prog_len = '0;
  logic [TO_W-1:0]   timeout_limit = '0;
  logic              ld_valid = 1'b0;
  logic [31:0]       ld_data = 32'd0;
  logic              ld_ready;
  logic              imem_we;
  logic [MEM_AW-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              cpu_halted = 1'b0;
  logic [4:0]        dbg_raddr;
  logic [31:0]       dbg_rdata;
  logic              dump_valid;
  logic [4:0]        dump_idx;
  logic [31:0]       dump_data;
  logic              dump_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              timeout;

  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    int plen;
    int limit;
    int halt_at;
    bit halt_pulse;
    bit bp;
    int exp_run;
    bit exp_to;
  } vec_t;

  vec_t vecs[7];

  mips_run_ctrl dut (
    .clk1          (clk1),
    .rst_n         (rst_n),
    .start         (start),
    .prog_len      (prog_len),
    .timeout_limit (timeout_limit),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_ready      (ld_ready),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .cpu_run       (cpu_run),
    .cpu_halted    (cpu_halted),
    .dbg_raddr     (dbg_raddr),
    .dbg_rdata     (dbg_rdata),
    .dump_valid    (dump_valid),
    .dump_idx      (dump_idx),
    .dump_data     (dump_data),
    .dump_ready    (dump_ready),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] reg_model(input logic [4:0] a);
    return {16'hC0DE, 3'b000, a, 3'b000, a};
  endfunction

  function automatic logic [31:0] prog_word(input int w);
    return 32'hA000_0000 ^ (32'(w) * 32'h0001_0003);
  endfunction

  assign dbg_rdata = reg_model(dbg_raddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_seq(input vec_t v);
    int w;
    int c;
    int k;
    int idx;
    @(negedge clk1);
    start         = 1'b1;
    prog_len      = MEM_AW'(v.plen);
    timeout_limit = TO_W'(v.limit);
    ld_valid      = 1'b0;
    cpu_halted    = 1'b0;
    dump_ready    = 1'b0;
    #1;
    chk("start_no_we", 32'(imem_we), 32'd0);
    @(posedge clk1);
    @(negedge clk1);
    start = 1'b0;
    #1;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_to_clr", 32'(timeout), 32'd0);

    w = 0;
    c = 0;
    while (w < v.plen && c < BUDGET) begin
      ld_valid = ((c % 3) != 1);
      ld_data  = prog_word(w);
      #1;
      chk("ld_ready", 32'(ld_ready), 32'd1);
      chk("load_no_run", 32'(cpu_run), 32'd0);
      chk("imem_we", 32'(imem_we), 32'(ld_valid));
      if (ld_valid) begin
        chk("imem_addr", 32'(imem_addr), 32'(w));
        chk("imem_wdata", imem_wdata, prog_word(w));
        w++;
      end
      c++;
      @(posedge clk1);
      @(negedge clk1);
    end
    ld_valid = 1'b0;
    if (w < v.plen) begin
      nfail++;
      $display("FAIL load_budget: got %0d words, expected %0d", w, v.plen);
    end

    k = 0;
    while (k < BUDGET) begin
      start = (k == 2) && (v.exp_run > 3);
      if (v.halt_at == 0) cpu_halted = 1'b0;
      else if (v.halt_pulse) cpu_halted = ((k + 1) == v.halt_at);
      else cpu_halted = ((k + 1) >= v.halt_at);
      #1;
      if (k == 0) chk("run_rise", 32'(cpu_run), 32'd1);
      if (!cpu_run) break;
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_no_ld_ready", 32'(ld_ready), 32'd0);
      chk("run_no_we", 32'(imem_we), 32'd0);
      k++;
      @(posedge clk1);
      @(negedge clk1);
    end
    start      = 1'b0;
    cpu_halted = 1'b0;
    chk("run_cycles", 32'(k), 32'(v.exp_run));
    chk("timeout_flag", 32'(timeout), 32'(v.exp_to));

`ifdef RUN_CTRL_DUMP_EN
    idx = 0;
    c   = 0;
    while (idx < NDUMP && c < BUDGET) begin
      dump_ready = v.bp ? (((c % 4) == 0) || ((c % 4) == 3)) : 1'b1;
      #1;
      chk("dump_valid", 32'(dump_valid), 32'd1);
      chk("dump_idx", 32'(dump_idx), 32'(idx));
      chk("dump_data", dump_data, reg_model(5'(idx)));
      chk("dump_not_done", 32'(done), 32'd0);
      if (dump_ready) idx++;
      c++;
      @(posedge clk1);
      @(negedge clk1);
    end
    dump_ready = 1'b0;
    if (idx < NDUMP) begin
      nfail++;
      $display("FAIL dump_budget: got %0d beats, expected %0d", idx, NDUMP);
    end
    #1;
    chk("dump_end_valid", 32'(dump_valid), 32'd0);
`else
    #1;
    chk("no_dump_valid", 32'(dump_valid), 32'd0);
`endif
    chk("done", 32'(done), 32'd1);
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_cpu_run", 32'(cpu_run), 32'd0);
    chk("final_timeout", 32'(timeout), 32'(v.exp_to));
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    //                 plen  limit halt pulse bp  run to
    vecs[0] = '{14,    0,    40,  1'b0, 1'b0, 40, 1'b0};
    vecs[1] = '{3,     20,   0,   1'b0, 1'b1, 20, 1'b1};
    vecs[2] = '{0,     10,   10,  1'b0, 1'b0, 10, 1'b0};
    vecs[3] = '{2,     5,    1,   1'b1, 1'b1, 5,  1'b1};
    vecs[4] = '{1,     0,    1,   1'b0, 1'b0, 2,  1'b0};
    vecs[5] = '{1,     1,    0,   1'b0, 1'b0, 1,  1'b1};
    vecs[6] = '{1023,  0,    3,   1'b0, 1'b1, 3,  1'b0};

    #12;
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dbg_raddr", 32'(dbg_raddr), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1);

    for (int i = 0; i < 7; i++) run_seq(vecs[i]);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk1);
    start         = 1'b1;
    prog_len      = '0;
    timeout_limit = '0;
    @(posedge clk1);
    @(negedge clk1);
    start = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    #1;
    chk("pre_rst_run", 32'(cpu_run), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_run", 32'(cpu_run), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1);
    @(negedge clk1);
    #1;
    chk("held_run", 32'(cpu_run), 32'd0);
    chk("held_busy", 32'(busy), 32'd0);
    chk("held_done", 32'(done), 32'd0);

    run_seq(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
